// File: rtl/osd_wb_pkg.sv
// Shared Wishbone definitions for the OSD MAM bus adapters: cycle-type
// constants, burst-type extension and the adapter FSM state encoding.
package osd_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_BUS,
        RD_BUS,
        RD_OUT
    } mam_wb_state_e;

    // Singles are always classic; bursts flag their final beat with CTI_END.
    function automatic logic [2:0] beat_cti(input logic burst, input logic last);
        if (!burst) begin
            return CTI_CLASSIC;
        end
        return last ? CTI_END : CTI_INCR;
    endfunction

endpackage

// File: rtl/osd_mam_wb_adapter.sv
// Bridges the MAM request/write/read handshakes onto a Wishbone B3 master,
// one beat at a time, keeping cyc asserted across a whole burst.
module osd_mam_wb_adapter
    import osd_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_burst,
    input  logic [13:0]             req_beats,

    input  logic                    write_valid,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    output logic                    write_ready,

    output logic                    read_valid,
    output logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    read_ready,

    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [2:0]              wb_cti_o,
    output logic [1:0]              wb_bte_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i
);

    localparam int BYTES = DATA_WIDTH / 8;

    mam_wb_state_e           state_q, state_d;
    logic                    rw_q;
    logic                    burst_q;
    logic                    cyc_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [13:0]             beats_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [BYTES-1:0]        sel_q;
    logic                    beat_done;
    logic                    last_beat;

    // An error completes the beat exactly like an ack; retry just holds it.
    assign beat_done = wb_ack_i | wb_err_i;
    assign last_beat = (beats_q == 14'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        write_ready = 1'b0;
        read_valid  = 1'b0;
        wb_stb_o    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    state_d = req_rw ? WR_DATA : RD_BUS;
                end
            end
            WR_DATA: begin
                write_ready = 1'b1;
                if (write_valid) begin
                    state_d = WR_BUS;
                end
            end
            WR_BUS: begin
                wb_stb_o = 1'b1;
                if (beat_done) begin
                    state_d = last_beat ? IDLE : WR_DATA;
                end else if (wb_rty_i) begin
                    state_d = WR_BUS;
                end
            end
            RD_BUS: begin
                wb_stb_o = 1'b1;
                if (beat_done) begin
                    state_d = RD_OUT;
                end else if (wb_rty_i) begin
                    state_d = RD_BUS;
                end
            end
            RD_OUT: begin
                read_valid = 1'b1;
                if (read_ready) begin
                    state_d = last_beat ? IDLE : RD_BUS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rw_q    <= 1'b0;
            burst_q <= 1'b0;
            cyc_q   <= 1'b0;
            addr_q  <= '0;
            beats_q <= 14'd0;
            wdata_q <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rw_q    <= req_rw;
                        burst_q <= req_burst;
                        addr_q  <= req_addr;
                        beats_q <= (!req_burst || req_beats == 14'd0) ? 14'd1 : req_beats;
                        if (!req_rw) begin
                            cyc_q <= 1'b1;
                            sel_q <= '1;
                        end
                    end
                end
                WR_DATA: begin
                    if (write_valid) begin
                        wdata_q <= write_data;
                        sel_q   <= burst_q ? '1 : write_strb;
                        cyc_q   <= 1'b1;
                    end
                end
                WR_BUS: begin
                    if (beat_done) begin
                        beats_q <= beats_q - 14'd1;
                        addr_q  <= addr_q + ADDR_WIDTH'(BYTES);
                        if (last_beat) begin
                            cyc_q <= 1'b0;
                        end
                    end
                end
                RD_BUS: begin
                    if (beat_done) begin
                        rdata_q <= wb_dat_i;
                    end
                end
                RD_OUT: begin
                    if (read_ready) begin
                        beats_q <= beats_q - 14'd1;
                        addr_q  <= addr_q + ADDR_WIDTH'(BYTES);
                        if (last_beat) begin
                            cyc_q <= 1'b0;
                        end
                    end
                end
                default: cyc_q <= 1'b0;
            endcase
        end
    end

    assign wb_cyc_o  = cyc_q;
    assign wb_we_o   = cyc_q & rw_q;
    assign wb_adr_o  = addr_q;
    assign wb_dat_o  = wdata_q;
    assign wb_sel_o  = sel_q;
    assign wb_cti_o  = cyc_q ? beat_cti(burst_q, last_beat) : CTI_CLASSIC;
    assign wb_bte_o  = BTE_LINEAR;
    assign read_data = rdata_q;

endmodule

// File: tb/tb_osd_mam_wb_adapter.sv
// Directed bench for osd_mam_wb_adapter: the bench plays both the MAM and
// the Wishbone slave, with hand-computed expectations for every beat.
module tb_osd_mam_wb_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_rw, req_burst;
    logic [31:0] req_addr;
    logic [13:0] req_beats;
    logic        req_ready;
    logic        write_valid, write_ready;
    logic [15:0] write_data;
    logic [1:0]  write_strb;
    logic        read_valid, read_ready;
    logic [15:0] read_data;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o;
    logic [15:0] wb_dat_o, wb_dat_i;
    logic [1:0]  wb_sel_o, wb_bte_o;
    logic [2:0]  wb_cti_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;

    int vectors = 0;
    int miscompares = 0;

    osd_mam_wb_adapter #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
        .write_valid(write_valid), .write_data(write_data),
        .write_strb(write_strb), .write_ready(write_ready),
        .read_valid(read_valid), .read_data(read_data), .read_ready(read_ready),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rw, input logic [31:0] adr,
                                 input logic burst, input logic [13:0] beats);
        checkOutput("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = adr;
        req_burst = burst;
        req_beats = beats;
        tick();
        req_valid = 1'b0;
        checkOutput("req_ready_busy", req_ready, 0);
    endtask

    // Entered with the adapter in WR_DATA; leaves it after the beat completes.
    task automatic writeBeat(input string tag, input logic [31:0] adr,
                             input logic [2:0] cti, input logic [1:0] sel,
                             input logic [15:0] data, input int gap,
                             input int waits, input int rty, input bit err,
                             input bit last);
        checkOutput({tag, ".wready"}, write_ready, 1);
        checkOutput({tag, ".stb_idle"}, wb_stb_o, 0);
        for (int i = 0; i < gap; i++) begin
            tick();
            checkOutput({tag, ".wready_gap"}, write_ready, 1);
            checkOutput({tag, ".stb_gap"}, wb_stb_o, 0);
        end
        write_valid = 1'b1;
        write_data  = data;
        tick();
        write_valid = 1'b0;
        write_data  = 16'h0000;
        checkOutput({tag, ".stb"}, wb_stb_o, 1);
        checkOutput({tag, ".cyc"}, wb_cyc_o, 1);
        checkOutput({tag, ".we"}, wb_we_o, 1);
        checkOutput({tag, ".adr"}, wb_adr_o, adr);
        checkOutput({tag, ".cti"}, wb_cti_o, cti);
        checkOutput({tag, ".sel"}, wb_sel_o, sel);
        checkOutput({tag, ".dat"}, wb_dat_o, data);
        checkOutput({tag, ".wready_bus"}, write_ready, 0);
        for (int i = 0; i < waits + rty; i++) begin
            wb_rty_i = (i >= waits);
            tick();
            checkOutput({tag, ".stb_hold"}, wb_stb_o, 1);
            checkOutput({tag, ".adr_hold"}, wb_adr_o, adr);
        end
        wb_rty_i = 1'b0;
        if (err) wb_err_i = 1'b1;
        else     wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        checkOutput({tag, ".stb_done"}, wb_stb_o, 0);
        checkOutput({tag, ".cyc_done"}, wb_cyc_o, !last);
        if (last) checkOutput({tag, ".req_ready"}, req_ready, 1);
        else      checkOutput({tag, ".wready_next"}, write_ready, 1);
    endtask

    // Entered with the adapter in RD_BUS; leaves it after read_ready is taken.
    task automatic readBeat(input string tag, input logic [31:0] adr,
                            input logic [2:0] cti, input logic [15:0] data,
                            input int stall, input int rty, input bit err,
                            input bit last);
        checkOutput({tag, ".stb"}, wb_stb_o, 1);
        checkOutput({tag, ".cyc"}, wb_cyc_o, 1);
        checkOutput({tag, ".we"}, wb_we_o, 0);
        checkOutput({tag, ".adr"}, wb_adr_o, adr);
        checkOutput({tag, ".cti"}, wb_cti_o, cti);
        checkOutput({tag, ".sel"}, wb_sel_o, 2'b11);
        for (int i = 0; i < rty; i++) begin
            wb_rty_i = 1'b1;
            tick();
            checkOutput({tag, ".stb_rty"}, wb_stb_o, 1);
            checkOutput({tag, ".adr_rty"}, wb_adr_o, adr);
            checkOutput({tag, ".rvalid_rty"}, read_valid, 0);
        end
        wb_rty_i   = 1'b0;
        wb_dat_i   = data;
        read_ready = 1'b0;
        if (err) wb_err_i = 1'b1;
        else     wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 16'hDEAD;
        checkOutput({tag, ".rvalid"}, read_valid, 1);
        checkOutput({tag, ".rdata"}, read_data, data);
        checkOutput({tag, ".stb_out"}, wb_stb_o, 0);
        checkOutput({tag, ".cyc_out"}, wb_cyc_o, 1);
        for (int i = 0; i < stall; i++) begin
            tick();
            checkOutput({tag, ".rvalid_stall"}, read_valid, 1);
            checkOutput({tag, ".rdata_stall"}, read_data, data);
            checkOutput({tag, ".stb_stall"}, wb_stb_o, 0);
            checkOutput({tag, ".cyc_stall"}, wb_cyc_o, 1);
        end
        read_ready = 1'b1;
        tick();
        read_ready = 1'b0;
        checkOutput({tag, ".rvalid_done"}, read_valid, 0);
        checkOutput({tag, ".cyc_done"}, wb_cyc_o, !last);
        if (last) checkOutput({tag, ".req_ready"}, req_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = 32'h0; req_burst = 1'b0;
        req_beats = 14'd0;
        write_valid = 1'b0; write_data = 16'h0; write_strb = 2'b00;
        read_ready = 1'b0;
        wb_dat_i = 16'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;

        tick();
        tick();
        checkOutput("rst.cyc", wb_cyc_o, 0);
        checkOutput("rst.stb", wb_stb_o, 0);
        checkOutput("rst.req_ready", req_ready, 0);
        checkOutput("rst.write_ready", write_ready, 0);
        checkOutput("rst.read_valid", read_valid, 0);
        checkOutput("rst.cti", wb_cti_o, 0);
        checkOutput("rst.sel", wb_sel_o, 0);
        checkOutput("rst.adr", wb_adr_o, 0);
        checkOutput("rst.read_data", read_data, 0);
        checkOutput("rst.bte", wb_bte_o, 0);
        rst = 1'b0;
        tick();

        $display("[TB] single write");
        write_strb = 2'b10;
        applyStimulus(1'b1, 32'h0000_1000, 1'b0, 14'd5);
        checkOutput("sw.cyc_wait", wb_cyc_o, 0);
        writeBeat("sw", 32'h0000_1000, 3'b000, 2'b10, 16'hBEEF, 0, 2, 0, 1'b0, 1'b1);

        $display("[TB] burst read of 4 with stalled beat 2");
        applyStimulus(1'b0, 32'h0000_2000, 1'b1, 14'd4);
        readBeat("br1", 32'h0000_2000, 3'b010, 16'h0011, 0, 0, 1'b0, 1'b0);
        readBeat("br2", 32'h0000_2002, 3'b010, 16'h0022, 3, 0, 1'b0, 1'b0);
        readBeat("br3", 32'h0000_2004, 3'b010, 16'h0033, 0, 0, 1'b0, 1'b0);
        readBeat("br4", 32'h0000_2006, 3'b111, 16'h0044, 0, 0, 1'b0, 1'b1);

        $display("[TB] burst write of 3 with write gaps");
        write_strb = 2'b01;
        applyStimulus(1'b1, 32'h0000_3000, 1'b1, 14'd3);
        writeBeat("bw1", 32'h0000_3000, 3'b010, 2'b11, 16'hA001, 0, 0, 0, 1'b0, 1'b0);
        writeBeat("bw2", 32'h0000_3002, 3'b010, 2'b11, 16'hA002, 2, 0, 0, 1'b0, 1'b0);
        writeBeat("bw3", 32'h0000_3004, 3'b111, 2'b11, 16'hA003, 5, 1, 0, 1'b0, 1'b1);

        $display("[TB] retry and error on a read burst");
        applyStimulus(1'b0, 32'h0000_6000, 1'b1, 14'd3);
        readBeat("re1", 32'h0000_6000, 3'b010, 16'h0101, 0, 3, 1'b0, 1'b0);
        readBeat("re2", 32'h0000_6002, 3'b010, 16'h0202, 0, 0, 1'b1, 1'b0);
        readBeat("re3", 32'h0000_6004, 3'b111, 16'h0303, 0, 0, 1'b0, 1'b1);

        $display("[TB] write burst with retry then error");
        applyStimulus(1'b1, 32'h0000_7000, 1'b1, 14'd2);
        writeBeat("we1", 32'h0000_7000, 3'b010, 2'b11, 16'h7001, 0, 0, 2, 1'b0, 1'b0);
        writeBeat("we2", 32'h0000_7002, 3'b111, 2'b11, 16'h7002, 1, 0, 0, 1'b1, 1'b1);

        $display("[TB] address wrap");
        applyStimulus(1'b0, 32'hFFFF_FFFE, 1'b1, 14'd2);
        readBeat("wr1", 32'hFFFF_FFFE, 3'b010, 16'h5A5A, 0, 0, 1'b0, 1'b0);
        readBeat("wr2", 32'h0000_0000, 3'b111, 16'hC3C3, 0, 0, 1'b0, 1'b1);

        $display("[TB] zero-length burst treated as one beat");
        applyStimulus(1'b0, 32'h0000_8000, 1'b1, 14'd0);
        readBeat("zb", 32'h0000_8000, 3'b111, 16'h8888, 0, 0, 1'b0, 1'b1);

        $display("[TB] reset mid-burst");
        applyStimulus(1'b0, 32'h0000_4000, 1'b1, 14'd4);
        readBeat("rb1", 32'h0000_4000, 3'b010, 16'h4444, 0, 0, 1'b0, 1'b0);
        checkOutput("rb2.stb", wb_stb_o, 1);
        checkOutput("rb2.adr", wb_adr_o, 32'h0000_4002);
        rst = 1'b1;
        tick();
        checkOutput("rstmid.cyc", wb_cyc_o, 0);
        checkOutput("rstmid.stb", wb_stb_o, 0);
        checkOutput("rstmid.read_valid", read_valid, 0);
        checkOutput("rstmid.req_ready", req_ready, 0);
        rst = 1'b0;
        tick();
        checkOutput("rstmid.adr", wb_adr_o, 0);
        applyStimulus(1'b0, 32'h0000_5000, 1'b0, 14'd0);
        readBeat("pr", 32'h0000_5000, 3'b000, 16'hA5A5, 1, 0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
